// File: rtl/ttm4_sequencer_pkg.sv
// Shared types for the TTM4 control sequencer: opcodes, FSM states, strobe vector.
// The optional single-step build is selected with TTM4_SINGLE_STEP_EN (see ttm4_sequencer.sv).
package ttm4_sequencer_pkg;

  localparam int unsigned TMR_W = 8;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LJD = 4'h1,
    OP_LJU = 4'h2,
    OP_JMP = 4'h3,
    OP_JNC = 4'h4,
    OP_OTD = 4'h5,
    OP_OTU = 4'h6,
    OP_IND = 4'h7,
    OP_INU = 4'h8,
    OP_MVO = 4'h9,
    OP_ILA = 4'hA,
    OP_ILB = 4'hB,
    OP_ILC = 4'hC,
    OP_ILD = 4'hD,
    OP_ILE = 4'hE,
    OP_HLT = 4'hF
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_EXEC2,
    S_WAIT_IR,
    S_NEXT,
    S_HALT
  } state_e;

  // Active-high internal view of the strobes; inverted only at the port.
  typedef struct packed {
    logic pc_open;
    logic pc_ld;
    logic pc_inc;
    logic imm_out;
    logic jrd_st;
    logic jru_st;
    logic ord_st;
    logic oru_st;
    logic jrd_out;
    logic jru_out;
    logic ird_out;
    logic iru_out;
    logic ir_ack;
  } strb_t;

  function automatic logic is_illegal(input op_e op);
    return (op >= OP_ILA) && (op <= OP_ILE);
  endfunction

  function automatic logic is_jump_taken(input op_e op, input logic carry);
    return (op == OP_JMP) || ((op == OP_JNC) && !carry);
  endfunction

endpackage

// File: rtl/ttm4_sequencer_if.sv
// Bus between the TTM4 sequencer and the ROM / register / PC / input-port blocks.
// STEP exists only when TTM4_SINGLE_STEP_EN is defined.
interface ttm4_sequencer_if;
  logic [7:0] INSTR;
  logic       CARRY;
  logic       IR_VALID;
  logic       IR_ACK;
  logic [3:0] IMM;
  logic       nIMM_OUT;
  logic       nPC_OPEN;
  logic       nPC_LD;
  logic       nPC_INC;
  logic       nJRD_ST;
  logic       nJRU_ST;
  logic       nORD_ST;
  logic       nORU_ST;
  logic       nJRD_OUT;
  logic       nJRU_OUT;
  logic       nIRD_OUT;
  logic       nIRU_OUT;
  logic       HALTED;
  logic       ERR;
`ifdef TTM4_SINGLE_STEP_EN
  logic       STEP;
`endif

  modport master (
    input  INSTR, CARRY, IR_VALID,
    output IR_ACK, IMM, nIMM_OUT, nPC_OPEN, nPC_LD, nPC_INC,
           nJRD_ST, nJRU_ST, nORD_ST, nORU_ST,
           nJRD_OUT, nJRU_OUT, nIRD_OUT, nIRU_OUT, HALTED, ERR
`ifdef TTM4_SINGLE_STEP_EN
    , input STEP
`endif
  );

  modport slave (
    output INSTR, CARRY, IR_VALID,
    input  IR_ACK, IMM, nIMM_OUT, nPC_OPEN, nPC_LD, nPC_INC,
           nJRD_ST, nJRU_ST, nORD_ST, nORU_ST,
           nJRD_OUT, nJRU_OUT, nIRD_OUT, nIRU_OUT, HALTED, ERR
`ifdef TTM4_SINGLE_STEP_EN
    , output STEP
`endif
  );
endinterface

// File: rtl/ttm4_ir_wait_timer.sv
// Down-counter bounding the IR wait; o_expire flags the last permitted wait cycle.
module ttm4_ir_wait_timer
  import ttm4_sequencer_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  input  logic             i_dec,
  input  logic             i_clr,
  output logic             o_expire
);

  logic [TMR_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - TMR_W'(1);
    end
  end

  assign o_expire = (r_count == TMR_W'(1));

endmodule

// File: rtl/ttm4_sequencer.sv
// TTM4 control sequencer: fetch/decode/execute FSM driving active-low register strobes.
// Define TTM4_SINGLE_STEP_EN to add the STEP input that gates the NEXT phase.
module ttm4_sequencer
  import ttm4_sequencer_pkg::*;
#(
  parameter int unsigned IR_TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  ttm4_sequencer_if.master  bus
);

  localparam logic [TMR_W-1:0] LP_TMO = TMR_W'(IR_TIMEOUT);

  state_e     r_state;
  state_e     w_state_n;
  logic [7:0] r_instr;
  strb_t      r_strb;
  strb_t      w_strb_n;
  logic [3:0] r_imm;
  logic       r_jump;
  logic       r_wait_done;
  logic       r_halted;
  logic       r_err;
  logic       w_jump_n;
  logic       w_wait_done_n;
  logic       w_err_set;
  logic       w_expire;
  op_e        w_op_cur;
  op_e        w_op_in;
`ifdef TTM4_SINGLE_STEP_EN
  logic       r_go;
  logic       w_go_n;
`endif

  assign w_op_cur = op_e'(r_instr[7:4]);
  assign w_op_in  = op_e'(bus.INSTR[7:4]);

  ttm4_ir_wait_timer u_timer (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_load     (w_state_n == S_EXEC),
    .i_load_val (LP_TMO),
    .i_dec      (w_state_n == S_WAIT_IR),
    .i_clr      (w_state_n == S_FETCH),
    .o_expire   (w_expire)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:    w_state_n = S_FETCH;
      S_FETCH:   w_state_n = S_EXEC;
      S_EXEC: begin
        case (w_op_cur)
          OP_IND, OP_INU: w_state_n = S_WAIT_IR;
          OP_MVO:         w_state_n = S_EXEC2;
          OP_HLT:         w_state_n = S_HALT;
          default:        w_state_n = S_NEXT;
        endcase
      end
      S_EXEC2:   w_state_n = S_NEXT;
      S_WAIT_IR: w_state_n = r_wait_done ? S_NEXT : S_WAIT_IR;
`ifdef TTM4_SINGLE_STEP_EN
      S_NEXT:    w_state_n = r_go ? S_FETCH : S_NEXT;
`else
      S_NEXT:    w_state_n = S_FETCH;
`endif
      S_HALT:    w_state_n = S_HALT;
      default:   w_state_n = S_IDLE;
    endcase
  end

  // Outputs are registered, so each cycle's strobes are decoded from the state being
  // entered and the inputs sampled on the edge that enters it.
  always_comb begin
    w_strb_n      = '0;
    w_jump_n      = r_jump;
    w_wait_done_n = 1'b0;
    w_err_set     = 1'b0;
`ifdef TTM4_SINGLE_STEP_EN
    w_go_n        = 1'b0;
`endif
    case (w_state_n)
      S_FETCH: w_strb_n.pc_open = 1'b1;
      S_EXEC: begin
        w_jump_n       = is_jump_taken(w_op_in, bus.CARRY);
        w_strb_n.pc_ld = w_jump_n;
        case (w_op_in)
          OP_LJD: begin w_strb_n.imm_out = 1'b1; w_strb_n.jrd_st = 1'b1; end
          OP_LJU: begin w_strb_n.imm_out = 1'b1; w_strb_n.jru_st = 1'b1; end
          OP_OTD: begin w_strb_n.imm_out = 1'b1; w_strb_n.ord_st = 1'b1; end
          OP_OTU: begin w_strb_n.imm_out = 1'b1; w_strb_n.oru_st = 1'b1; end
          OP_MVO: begin w_strb_n.jrd_out = 1'b1; w_strb_n.ord_st = 1'b1; end
          default: w_err_set = is_illegal(w_op_in);
        endcase
      end
      S_EXEC2: begin
        w_strb_n.jru_out = 1'b1;
        w_strb_n.oru_st  = 1'b1;
      end
      S_WAIT_IR: begin
        // Data wins over the timeout when both land on the same cycle.
        if (bus.IR_VALID) begin
          if (w_op_cur == OP_IND) begin
            w_strb_n.ird_out = 1'b1;
            w_strb_n.jrd_st  = 1'b1;
          end else begin
            w_strb_n.iru_out = 1'b1;
            w_strb_n.jru_st  = 1'b1;
          end
          w_strb_n.ir_ack = 1'b1;
          w_wait_done_n   = 1'b1;
        end else if (w_expire) begin
          w_err_set     = 1'b1;
          w_wait_done_n = 1'b1;
        end
      end
      S_NEXT: begin
`ifdef TTM4_SINGLE_STEP_EN
        w_go_n          = bus.STEP;
        w_strb_n.pc_inc = bus.STEP && !r_jump;
`else
        w_strb_n.pc_inc = !r_jump;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_instr     <= '0;
      r_strb      <= '0;
      r_imm       <= '0;
      r_jump      <= 1'b0;
      r_wait_done <= 1'b0;
      r_halted    <= 1'b0;
      r_err       <= 1'b0;
`ifdef TTM4_SINGLE_STEP_EN
      r_go        <= 1'b0;
`endif
    end else begin
      if (r_state == S_FETCH) r_instr <= bus.INSTR;
      if (w_strb_n.imm_out)   r_imm   <= bus.INSTR[3:0];
      if (w_state_n == S_HALT) r_halted <= 1'b1;
      if (w_err_set)           r_err    <= 1'b1;
      r_strb      <= w_strb_n;
      r_jump      <= w_jump_n;
      r_wait_done <= w_wait_done_n;
`ifdef TTM4_SINGLE_STEP_EN
      r_go        <= w_go_n;
`endif
    end
  end

  assign bus.nPC_OPEN = ~r_strb.pc_open;
  assign bus.nPC_LD   = ~r_strb.pc_ld;
  assign bus.nPC_INC  = ~r_strb.pc_inc;
  assign bus.nIMM_OUT = ~r_strb.imm_out;
  assign bus.nJRD_ST  = ~r_strb.jrd_st;
  assign bus.nJRU_ST  = ~r_strb.jru_st;
  assign bus.nORD_ST  = ~r_strb.ord_st;
  assign bus.nORU_ST  = ~r_strb.oru_st;
  assign bus.nJRD_OUT = ~r_strb.jrd_out;
  assign bus.nJRU_OUT = ~r_strb.jru_out;
  assign bus.nIRD_OUT = ~r_strb.ird_out;
  assign bus.nIRU_OUT = ~r_strb.iru_out;
  assign bus.IR_ACK   = r_strb.ir_ack;
  assign bus.IMM      = r_imm;
  assign bus.HALTED   = r_halted;
  assign bus.ERR      = r_err;

endmodule
